// File: rtl/mt9v034_lvds_word_gen_if.sv
// Pixel-stream handshake into the MT9V034 LVDS word generator.
interface mt9v034_lvds_word_gen_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_data;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;

    modport master (
        output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/mt9v034_lvds_word_gen.sv
// Packs pixels into 18-bit start/stop framed LVDS words, preceded by a training
// preamble, with a programmable bit slip of the outgoing stream.
//
// state  | meaning
// IDLE   | word register 0, not accepting pixels; waits for enable
// TRAIN  | emits TRAIN_LEN train words for the receive bit aligner
// STREAM | accepts pixels; idle words fill cycles without a transfer
module mt9v034_lvds_word_gen #(
    parameter int unsigned TRAIN_LEN = 4352
) (
    input  logic                          dlo_clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [4:0]                    bit_rot,
    mt9v034_lvds_word_gen_if.slave        pix,
    output logic                          dlo_valid_o,
    output logic [17:0]                   dlo_o,
    output logic                          trained,
    output logic                          underrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        TRAIN  = 3'b010,
        STREAM = 3'b100
    } state_t;

    localparam logic [17:0] TRAIN_WORD = 18'h08555;
    localparam logic [17:0] IDLE_WORD  = 18'h00001;
    localparam logic [15:0] TRAIN_TC   = 16'(TRAIN_LEN - 1);

    state_t      state;
    logic [17:0] cur;
    logic [17:0] prev;
    logic [4:0]  rot;
    logic [15:0] train_cnt;
    logic        line_open;
    logic        valid_d1;

    logic        xfer;
    logic        line_open_nxt;
    logic        stream_exit;
    logic [17:0] pix_word;
    logic [17:0] rot_word;

    assign xfer          = pix.pix_valid & pix.pix_ready;
    assign line_open_nxt = xfer ? ~pix.pix_eol : line_open;
    // A pixel accepted while stopping still opens a line, so the stop waits for its eol.
    assign stream_exit   = ~enable & ~line_open_nxt;
    assign pix_word      = {1'b0, 2'b10, 1'b0, pix.pix_eof, pix.pix_eol, pix.pix_sof,
                            pix.pix_data, 1'b1};
    assign rot_word      = 18'({cur, prev} >> (6'd18 - {1'b0, rot}));

    always_ff @(posedge dlo_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur           <= '0;
            prev          <= '0;
            rot           <= '0;
            train_cnt     <= '0;
            line_open     <= 1'b0;
            valid_d1      <= 1'b0;
            dlo_valid_o   <= 1'b0;
            dlo_o         <= '0;
            trained       <= 1'b0;
            underrun      <= 1'b0;
            pix.pix_ready <= 1'b0;
        end else begin
            prev        <= cur;
            valid_d1    <= (state != IDLE);
            dlo_valid_o <= valid_d1;
            dlo_o       <= rot_word;

            unique case (state)
                IDLE: begin
                    cur           <= '0;
                    line_open     <= 1'b0;
                    trained       <= 1'b0;
                    pix.pix_ready <= 1'b0;
                    if (enable) begin
                        rot       <= (bit_rot > 5'd17) ? 5'd0 : bit_rot;
                        train_cnt <= '0;
                        state     <= TRAIN;
                    end
                end
                TRAIN: begin
                    cur       <= TRAIN_WORD;
                    train_cnt <= train_cnt + 16'd1;
                    if (!enable) begin
                        state   <= IDLE;
                        trained <= 1'b0;
                    end else if (train_cnt == TRAIN_TC) begin
                        state         <= STREAM;
                        trained       <= 1'b1;
                        pix.pix_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    cur       <= xfer ? pix_word : IDLE_WORD;
                    line_open <= line_open_nxt;
                    if (!xfer && line_open) begin
                        underrun <= 1'b1;
                    end
                    if (stream_exit) begin
                        state         <= IDLE;
                        trained       <= 1'b0;
                        pix.pix_ready <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    trained       <= 1'b0;
                    pix.pix_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
